// File: rtl/ysyx_23060062_rv32_idu.sv
// RV32I decode stage feeding ysyx_23060062_rv32_alu.
// Decodes the fetched instruction combinationally and reads the register file
// in the same cycle. The decoded bundle is placed in a 2-entry skid buffer, so
// the fetch-side ready comes from a register and never depends on ALU ready.
// 16-bit (RV32C) encodings are not expanded; they decode as illegal.
module ysyx_23060062_rv32_idu #(
  parameter int               XLEN   = 32,
  parameter logic [XLEN-1:0]  RST_PC = 32'h8000_0000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [31:0]     i_in_inst,
  input  logic [XLEN-1:0] i_in_pc,
  output logic [4:0]      o_rs1_addr,
  output logic [4:0]      o_rs2_addr,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [31:0]     o_out_en,
  output logic [2:0]      o_out_type,
  output logic [7:0]      o_out_funct3_en,
  output logic [6:0]      o_out_funct7,
  output logic [XLEN-1:0] o_out_src1,
  output logic [XLEN-1:0] o_out_src2,
  output logic [XLEN-1:0] o_out_st_data,
  output logic [4:0]      o_out_rd,
  output logic [XLEN-1:0] o_out_pc
);

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_FENCE  = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  localparam logic [2:0] TYPE_R   = 3'd0;
  localparam logic [2:0] TYPE_I   = 3'd1;
  localparam logic [2:0] TYPE_S   = 3'd2;
  localparam logic [2:0] TYPE_B   = 3'd3;
  localparam logic [2:0] TYPE_U   = 3'd4;
  localparam logic [2:0] TYPE_J   = 3'd5;
  localparam logic [2:0] TYPE_SYS = 3'd6;
  localparam logic [2:0] TYPE_ILL = 3'd7;

  typedef struct packed {
    logic [31:0]     en;
    logic [2:0]      typ;
    logic [7:0]      f3_en;
    logic [6:0]      f7;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [XLEN-1:0] st_data;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
  } bundle_t;

  logic [4:0]      w_opc;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [7:0]      w_f3_oh;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;
  logic            w_legal;
  bundle_t         w_dec;
  logic            w_in_fire;
  logic            w_out_fire;

  bundle_t r_out;
  bundle_t r_skid;
  logic    r_out_valid;
  logic    r_skid_valid;
  logic    r_in_ready;

  assign w_opc      = i_in_inst[6:2];
  assign w_f3       = i_in_inst[14:12];
  assign w_f7       = i_in_inst[31:25];
  assign w_f3_oh    = 8'd1 << w_f3;
  assign o_rs1_addr = i_in_inst[19:15];
  assign o_rs2_addr = i_in_inst[24:20];

  // x0 reads are forced to zero here so the regfile need not guarantee it.
  assign w_rs1_val = (o_rs1_addr == 5'd0) ? '0 : i_rs1_data;
  assign w_rs2_val = (o_rs2_addr == 5'd0) ? '0 : i_rs2_data;

  assign w_imm_i = {{20{i_in_inst[31]}}, i_in_inst[31:20]};
  assign w_imm_s = {{20{i_in_inst[31]}}, i_in_inst[31:25], i_in_inst[11:7]};
  assign w_imm_b = {{19{i_in_inst[31]}}, i_in_inst[31], i_in_inst[7],
                    i_in_inst[30:25], i_in_inst[11:8], 1'b0};
  assign w_imm_u = {i_in_inst[31:12], 12'b0};
  assign w_imm_j = {{11{i_in_inst[31]}}, i_in_inst[31], i_in_inst[19:12],
                    i_in_inst[20], i_in_inst[30:21], 1'b0};

  // Combinational decode of the presented instruction into an ALU bundle.
  always_comb begin
    w_legal       = 1'b0;
    w_dec         = '0;
    w_dec.pc      = i_in_pc;
    if (i_in_inst[1:0] == 2'b11) begin
      case (w_opc)
        OPC_LOAD, OPC_OP_IMM: begin
          w_legal       = 1'b1;
          w_dec.typ     = TYPE_I;
          w_dec.src1    = w_rs1_val;
          w_dec.src2    = w_imm_i;
          w_dec.f3_en   = w_f3_oh;
          w_dec.rd      = i_in_inst[11:7];
          // Shift-immediates carry the SRLI/SRAI distinction in funct7.
          if (w_opc == OPC_OP_IMM && (w_f3 == 3'b001 || w_f3 == 3'b101)) begin
            w_dec.f7 = w_f7;
          end
        end
        OPC_JALR: begin
          w_legal       = 1'b1;
          w_dec.typ     = TYPE_I;
          w_dec.src1    = i_in_pc;
          w_dec.src2    = 32'd4;
          w_dec.f3_en   = w_f3_oh;
          w_dec.rd      = i_in_inst[11:7];
        end
        OPC_AUIPC: begin
          w_legal       = 1'b1;
          w_dec.typ     = TYPE_U;
          w_dec.src1    = i_in_pc;
          w_dec.src2    = w_imm_u;
          w_dec.rd      = i_in_inst[11:7];
        end
        OPC_LUI: begin
          w_legal       = 1'b1;
          w_dec.typ     = TYPE_U;
          w_dec.src2    = w_imm_u;
          w_dec.rd      = i_in_inst[11:7];
        end
        OPC_STORE: begin
          w_legal       = 1'b1;
          w_dec.typ     = TYPE_S;
          w_dec.src1    = w_rs1_val;
          w_dec.src2    = w_imm_s;
          w_dec.f3_en   = w_f3_oh;
          w_dec.st_data = w_rs2_val;
        end
        OPC_OP: begin
          if (w_f7 == 7'b0000000 ||
              (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101))) begin
            w_legal     = 1'b1;
            w_dec.typ   = TYPE_R;
            w_dec.src1  = w_rs1_val;
            w_dec.src2  = w_rs2_val;
            w_dec.f3_en = w_f3_oh;
            w_dec.f7    = w_f7;
            w_dec.rd    = i_in_inst[11:7];
          end
        end
        OPC_BRANCH: begin
          w_legal       = 1'b1;
          w_dec.typ     = TYPE_B;
          w_dec.src1    = w_rs1_val;
          w_dec.src2    = w_rs2_val;
          w_dec.f3_en   = w_f3_oh;
        end
        OPC_JAL: begin
          w_legal       = 1'b1;
          w_dec.typ     = TYPE_J;
          w_dec.src1    = i_in_pc;
          w_dec.src2    = 32'd4;
          w_dec.rd      = i_in_inst[11:7];
        end
        OPC_FENCE, OPC_SYSTEM: begin
          w_legal       = 1'b1;
          w_dec.typ     = TYPE_SYS;
          w_dec.src1    = w_rs1_val;
          w_dec.src2    = w_imm_i;
          w_dec.rd      = i_in_inst[11:7];
        end
        default: w_legal = 1'b0;
      endcase
    end
    if (w_legal) begin
      w_dec.en = 32'd1 << w_opc;
    end else begin
      w_dec     = '0;
      w_dec.pc  = i_in_pc;
      w_dec.typ = TYPE_ILL;
    end
  end

  assign w_in_fire  = i_in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & i_out_ready;

  // Skid buffer: OUT drives the ALU, SKID catches the one bundle accepted
  // while OUT is stalled; in_ready is simply "SKID is empty", registered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out        <= '0;
      r_out.pc     <= RST_PC;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (i_flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (!r_out_valid || w_out_fire) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end else if (w_in_fire) begin
        r_out       <= w_dec;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_in_fire) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
      r_in_ready   <= 1'b0;
    end
  end

  assign o_in_ready      = r_in_ready;
  assign o_out_valid     = r_out_valid;
  assign o_out_en        = r_out.en;
  assign o_out_type      = r_out.typ;
  assign o_out_funct3_en = r_out.f3_en;
  assign o_out_funct7    = r_out.f7;
  assign o_out_src1      = r_out.src1;
  assign o_out_src2      = r_out.src2;
  assign o_out_st_data   = r_out.st_data;
  assign o_out_rd        = r_out.rd;
  assign o_out_pc        = r_out.pc;

endmodule

// File: tb/tb_ysyx_23060062_rv32_idu.sv
// Bench for the RV32I decode stage: directed decode vectors, a random
// instruction stream with a reference decoder and scoreboard, skid-buffer
// backpressure, flush and mid-transfer reset.
module tb_ysyx_23060062_rv32_idu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] en;
    logic [2:0]  typ;
    logic [7:0]  f3;
    logic [6:0]  f7;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] st;
    logic [4:0]  rd;
    logic [31:0] pc;
  } bundle_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] en;
    logic [2:0]  typ;
    logic [7:0]  f3;
    logic [6:0]  f7;
    logic        chk_src;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] st;
    logic [4:0]  rd;
  } dvec_t;

  logic        i_clk = 1'b0;
  logic        i_rst, i_flush, i_in_valid, i_out_ready;
  logic [31:0] i_in_inst, i_in_pc, i_rs1_data, i_rs2_data;
  logic        o_in_ready, o_out_valid;
  logic [4:0]  o_rs1_addr, o_rs2_addr, o_out_rd;
  logic [31:0] o_out_en, o_out_src1, o_out_src2, o_out_st_data, o_out_pc;
  logic [2:0]  o_out_type;
  logic [7:0]  o_out_funct3_en;
  logic [6:0]  o_out_funct7;

  logic [31:0] rf [32];
  bundle_t     q[$];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 i_clk = ~i_clk;

  assign i_rs1_data = rf[o_rs1_addr];
  assign i_rs2_data = rf[o_rs2_addr];

  ysyx_23060062_rv32_idu #(.XLEN(32), .RST_PC(RST_PC)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_in_inst(i_in_inst), .i_in_pc(i_in_pc),
    .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_en(o_out_en), .o_out_type(o_out_type),
    .o_out_funct3_en(o_out_funct3_en), .o_out_funct7(o_out_funct7),
    .o_out_src1(o_out_src1), .o_out_src2(o_out_src2),
    .o_out_st_data(o_out_st_data), .o_out_rd(o_out_rd), .o_out_pc(o_out_pc)
  );

  function automatic bundle_t dut_out();
    return {o_out_en, o_out_type, o_out_funct3_en, o_out_funct7,
            o_out_src1, o_out_src2, o_out_st_data, o_out_rd, o_out_pc};
  endfunction

  // Reference decoder, keyed on the full 7-bit opcode.
  function automatic bundle_t model(input logic [31:0] inst, input logic [31:0] pc,
                                    input logic [31:0] r1raw, input logic [31:0] r2raw);
    bundle_t     b;
    logic        legal;
    logic [31:0] r1, r2, ii, is, ib, iu;
    logic [7:0]  f3;
    r1 = (inst[19:15] == 5'd0) ? 32'd0 : r1raw;
    r2 = (inst[24:20] == 5'd0) ? 32'd0 : r2raw;
    ii = {{20{inst[31]}}, inst[31:20]};
    is = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    ib = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    iu = {inst[31:12], 12'h000};
    f3 = 8'd1 << inst[14:12];
    b = '0;
    b.pc = pc;
    legal = 1'b1;
    if (inst[1:0] != 2'b11) legal = 1'b0;
    else case (inst[6:0])
      7'h03, 7'h13: begin
        b.typ = 3'd1; b.src1 = r1; b.src2 = ii; b.f3 = f3; b.rd = inst[11:7];
        if (inst[6:0] == 7'h13 && inst[13:12] == 2'b01) b.f7 = inst[31:25];
      end
      7'h67: begin b.typ = 3'd1; b.src1 = pc; b.src2 = 32'd4; b.f3 = f3; b.rd = inst[11:7]; end
      7'h17: begin b.typ = 3'd4; b.src1 = pc; b.src2 = iu; b.rd = inst[11:7]; end
      7'h37: begin b.typ = 3'd4; b.src2 = iu; b.rd = inst[11:7]; end
      7'h23: begin b.typ = 3'd2; b.src1 = r1; b.src2 = is; b.f3 = f3; b.st = r2; end
      7'h33: begin
        if (inst[31:25] == 7'h00 ||
            (inst[31:25] == 7'h20 && (inst[14:12] == 3'd0 || inst[14:12] == 3'd5))) begin
          b.typ = 3'd0; b.src1 = r1; b.src2 = r2; b.f3 = f3; b.f7 = inst[31:25]; b.rd = inst[11:7];
        end else legal = 1'b0;
      end
      7'h63: begin b.typ = 3'd3; b.src1 = r1; b.src2 = r2; b.f3 = f3; if (ib == 32'hFFFF_FFFF) b.src2 = r2; end
      7'h6F: begin b.typ = 3'd5; b.src1 = pc; b.src2 = 32'd4; b.rd = inst[11:7]; end
      7'h0F, 7'h73: begin b.typ = 3'd6; b.src1 = r1; b.src2 = ii; b.rd = inst[11:7]; end
      default: legal = 1'b0;
    endcase
    if (legal) b.en = 32'd1 << inst[6:2];
    else begin
      b = '0; b.pc = pc; b.typ = 3'd7;
    end
    return b;
  endfunction

  // One cycle of stimulus; records the expected bundle when fetch fires.
  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    @(negedge i_clk);
    i_in_valid  = v;
    i_in_inst   = inst;
    i_in_pc     = pc;
    i_out_ready = ordy;
    i_flush     = fl;
    if (fl) q.delete();
    else if (v && o_in_ready) q.push_back(model(inst, pc, rf[inst[19:15]], rf[inst[24:20]]));
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_flush = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b0;
    i_in_inst = 32'h0; i_in_pc = 32'h0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    n_vec++;
    if ({o_out_valid, o_in_ready} !== 2'b01) begin
      n_err++; $display("FAIL reset_hs got valid/ready=%b required=01", {o_out_valid, o_in_ready});
    end
    n_vec++;
    if (o_out_pc !== RST_PC) begin
      n_err++; $display("FAIL reset_pc got=%h required=%h", o_out_pc, RST_PC);
    end
    n_vec++;
    if ({o_out_en, o_out_type, o_out_funct3_en, o_out_funct7, o_out_src1, o_out_src2,
         o_out_st_data, o_out_rd} !== '0) begin
      n_err++; $display("FAIL reset_fields got en=%h type=%0d src1=%h src2=%h rd=%0d required all 0",
                        o_out_en, o_out_type, o_out_src1, o_out_src2, o_out_rd);
    end
    i_rst = 1'b0;
  endtask

  task automatic test_decode_directed();
    dvec_t   dv[9];
    bundle_t exp;
    dv[0] = '{32'h00510093, 32'h0000_0010, 3'd1, 8'h01, 7'h00, 1'b1, 32'h10, 32'h5, 32'h0, 5'd1};
    dv[1] = '{32'h123452B7, 32'h0000_2000, 3'd4, 8'h00, 7'h00, 1'b1, 32'h0, 32'h12345000, 32'h0, 5'd5};
    dv[2] = '{32'h402081B3, 32'h0000_1000, 3'd0, 8'h01, 7'h20, 1'b1, 32'h11110001, 32'h10, 32'h0, 5'd3};
    dv[3] = '{32'h202081B3, 32'h0, 3'd7, 8'h00, 7'h00, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0};
    dv[4] = '{32'h00004501, 32'h0, 3'd7, 8'h00, 7'h00, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0};
    dv[5] = '{32'h000000EF, 32'h0800_0000, 3'd5, 8'h00, 7'h00, 1'b1, 32'h8000_0114, 32'h4, 32'h0, 5'd1};
    dv[6] = '{32'h0020A423, 32'h0000_0100, 3'd2, 8'h04, 7'h00, 1'b1, 32'h11110001, 32'h8, 32'h10, 5'd0};
    dv[7] = '{32'h00700093, 32'h0000_0010, 3'd1, 8'h01, 7'h00, 1'b1, 32'h0, 32'h7, 32'h0, 5'd1};
    dv[8] = '{32'h4030D213, 32'h0000_0010, 3'd1, 8'h20, 7'h20, 1'b1, 32'h11110001, 32'h403, 32'h0, 5'd4};
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, dv[i].inst, 32'h8000_0100 + 32'(4 * i), 1'b1, 1'b0);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      n_vec++;
      if (o_out_valid !== 1'b1) begin
        n_err++; $display("FAIL dir%0d_valid got=%b required=1", i, o_out_valid);
      end
      n_vec++;
      if ({o_out_en, o_out_type, o_out_funct3_en, o_out_funct7, o_out_rd} !==
          {dv[i].en, dv[i].typ, dv[i].f3, dv[i].f7, dv[i].rd}) begin
        n_err++; $display("FAIL dir%0d_fields got en=%h type=%0d f3=%h f7=%h rd=%0d required en=%h type=%0d f3=%h f7=%h rd=%0d",
                          i, o_out_en, o_out_type, o_out_funct3_en, o_out_funct7, o_out_rd,
                          dv[i].en, dv[i].typ, dv[i].f3, dv[i].f7, dv[i].rd);
      end
      if (dv[i].chk_src) begin
        n_vec++;
        if ({o_out_src1, o_out_src2, o_out_st_data} !== {dv[i].s1, dv[i].s2, dv[i].st}) begin
          n_err++; $display("FAIL dir%0d_src got src1=%h src2=%h st=%h required src1=%h src2=%h st=%h",
                            i, o_out_src1, o_out_src2, o_out_st_data, dv[i].s1, dv[i].s2, dv[i].st);
        end
      end
      if (o_out_valid && i_out_ready && q.size() > 0) begin
        exp = q.pop_front();
        n_vec++;
        if (dut_out() !== exp) begin
          n_err++; $display("FAIL dir%0d_model got=%h required=%h", i, dut_out(), exp);
        end
      end
    end
  endtask

  task automatic test_random_stream();
    logic [6:0]  ops[11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
    logic [31:0] inst;
    int          sel;
    bundle_t     exp;
    for (int c = 0; c < 400 + 30; c++) begin
      inst = $urandom;
      sel  = $urandom_range(0, 13);
      if (sel <= 10) inst[6:0] = ops[sel];
      if (sel == 5 && $urandom_range(0, 1) == 1) inst[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      if (sel == 12) inst[1:0] = 2'($urandom_range(0, 2));
      if (sel == 13) inst[6:0] = 7'h33;
      if (c < 400)
        drive($urandom_range(0, 3) != 0, inst, {$urandom} & 32'hFFFF_FFFC, $urandom_range(0, 3) != 0, 1'b0);
      else
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      if (o_out_valid && i_out_ready) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL stream_extra got=%h required=no bundle", dut_out());
        end else begin
          exp = q.pop_front();
          if (dut_out() !== exp) begin
            n_err++; $display("FAIL stream_bundle got=%h required=%h", dut_out(), exp);
          end
        end
      end
    end
    n_vec++;
    if (q.size() != 0 || o_out_valid !== 1'b0) begin
      n_err++; $display("FAIL stream_drain got pending=%0d valid=%b required pending=0 valid=0", q.size(), o_out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins[3] = '{32'h00108093, 32'h00210113, 32'h00318193};
    bundle_t     exp;
    int          popped = 0;
    logic        taken2 = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b1, ins[i], 32'h8000_0200 + 32'(4 * i), 1'b0, 1'b0);
    n_vec++;
    if (q.size() != 2 || o_in_ready !== 1'b0 || o_out_valid !== 1'b1) begin
      n_err++; $display("FAIL b2b_full got accepted=%0d in_ready=%b valid=%b required 2/0/1", q.size(), o_in_ready, o_out_valid);
    end
    for (int c = 0; c < 12; c++) begin
      if (!taken2 && o_in_ready) taken2 = 1'b1;
      drive(!taken2 || !o_in_ready ? 1'b1 : 1'b0, ins[2], 32'h8000_0208, 1'b1, 1'b0);
      if (o_out_valid && i_out_ready) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL b2b_extra got=%h required=no bundle", dut_out());
        end else begin
          exp = q.pop_front();
          popped++;
          if (dut_out() !== exp) begin
            n_err++; $display("FAIL b2b_order got=%h required=%h", dut_out(), exp);
          end
        end
      end
      if (taken2) begin
        i_in_valid = 1'b0;
      end
    end
    n_vec++;
    if (popped != 3 || o_in_ready !== 1'b1) begin
      n_err++; $display("FAIL b2b_drain got emerged=%0d in_ready=%b required 3/1", popped, o_in_ready);
    end
  endtask

  task automatic test_flush();
    bundle_t exp;
    int      stale = 0;
    drive(1'b1, 32'h00108093, 32'h8000_0300, 1'b0, 1'b0);
    drive(1'b1, 32'h00210113, 32'h8000_0304, 1'b0, 1'b0);
    drive(1'b1, 32'h00318193, 32'h8000_0308, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    n_vec++;
    if ({o_out_valid, o_in_ready} !== 2'b01) begin
      n_err++; $display("FAIL flush_full got valid/ready=%b required=01", {o_out_valid, o_in_ready});
    end
    drive(1'b1, 32'h00420213, 32'h8000_0310, 1'b0, 1'b0);
    drive(1'b1, 32'h00528293, 32'h8000_0314, 1'b0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      if (o_out_valid !== 1'b0) stale++;
    end
    n_vec++;
    if (stale != 0 || o_in_ready !== 1'b1) begin
      n_err++; $display("FAIL flush_stale got stale_cycles=%0d in_ready=%b required 0/1", stale, o_in_ready);
    end
    drive(1'b1, 32'h00630313, 32'h8000_0320, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    n_vec++;
    if (o_out_valid !== 1'b1 || q.size() != 1) begin
      n_err++; $display("FAIL flush_resume got valid=%b pending=%0d required 1/1", o_out_valid, q.size());
    end else begin
      exp = q.pop_front();
      if (dut_out() !== exp) begin
        n_err++; $display("FAIL flush_resume_bundle got=%h required=%h", dut_out(), exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'h00108093, 32'h8000_0400, 1'b0, 1'b0);
    drive(1'b1, 32'h00210113, 32'h8000_0404, 1'b0, 1'b0);
    @(negedge i_clk);
    i_rst = 1'b1; i_flush = 1'b1; i_in_valid = 1'b1; i_in_inst = 32'h00318193;
    @(negedge i_clk);
    q.delete();
    n_vec++;
    if ({o_out_valid, o_in_ready, o_out_pc, o_out_en, o_out_src1} !== {2'b01, RST_PC, 64'h0}) begin
      n_err++; $display("FAIL rst_mid got valid=%b ready=%b pc=%h en=%h src1=%h required 0/1/%h/0/0",
                        o_out_valid, o_in_ready, o_out_pc, o_out_en, o_out_src1, RST_PC);
    end
    i_rst = 1'b0; i_flush = 1'b0; i_in_valid = 1'b0;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) rf[r] = $urandom;
    rf[0] = 32'hDEAD_BEEF;
    rf[1] = 32'h1111_0001;
    rf[2] = 32'h0000_0010;
    test_reset();
    test_decode_directed();
    test_random_stream();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
